read_sched_arbiter: RTL and testbench

READ_SCHED_ARBITER -- requirements
Module: read_sched_arbiter

---
 rtl/read_sched_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_read_sched_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_sched_arbiter.sv
// Read scheduler: picks one of NUM_PRIO packet queues (strict priority or weighted
// round robin), asks the queue manager for that packet's SRAM addresses, issues the
// SRAM reads and streams the returned words out framed by rd_sop / rd_eop.
//
// Ports
//   clk, rst        single clock, synchronous active-high reset
//   sp0_wrr1        0 = strict priority (highest index wins), 1 = WRR
//   ready           downstream asks for the next packet
//   prepared        per-queue "has a packet" flags
//   wrr_weights     per-queue WRR weight, queue p in [p*WEIGHT_W +: WEIGHT_W]
//   addr_in/vld/last  address stream from the queue manager
//   mem_data        SRAM read data
//   grant/grant_prio  one-hot and binary index of the granted queue
//   addr_req        address request towards the queue manager
//   sram_en/addr    SRAM read port
//   rd_sop/vld/eop/data  packet output stream
module read_sched_arbiter #(
  parameter int unsigned NUM_PRIO = 8,
  parameter int unsigned PRIO_W   = 3,
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned WEIGHT_W = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sp0_wrr1,
  input  logic                         ready,
  input  logic [NUM_PRIO-1:0]          prepared,
  input  logic [NUM_PRIO*WEIGHT_W-1:0] wrr_weights,
  input  logic [ADDR_W-1:0]            addr_in,
  input  logic                         addr_vld,
  input  logic                         addr_last,
  input  logic [DATA_W-1:0]            mem_data,
  output logic [NUM_PRIO-1:0]          grant,
  output logic [PRIO_W-1:0]            grant_prio,
  output logic                         addr_req,
  output logic                         sram_en,
  output logic [ADDR_W-1:0]            sram_addr,
  output logic                         rd_sop,
  output logic                         rd_vld,
  output logic                         rd_eop,
  output logic [DATA_W-1:0]            rd_data
);

  localparam logic [PRIO_W-1:0] LastPrio = PRIO_W'(NUM_PRIO - 1);

  typedef enum logic [2:0] {StIdle, StArb, StSop, StData, StDrain, StEop} state_e;

  state_e                state_q, state_d;
  logic [PRIO_W-1:0]     ptr_q, ptr_d;
  logic [WEIGHT_W-1:0]   credit_q, credit_d;

  logic [NUM_PRIO-1:0]   grant_d;
  logic [PRIO_W-1:0]     grant_prio_d;
  logic                  addr_req_d, sram_en_d, rd_sop_d, rd_vld_d, rd_eop_d;
  logic [ADDR_W-1:0]     sram_addr_d;
  logic [DATA_W-1:0]     rd_data_d;

  // Arbitration candidates
  logic                  sp_found, srch_found, stay;
  logic [PRIO_W-1:0]     sp_win, srch_win, wrr_win, idx, wrr_ptr;
  logic [WEIGHT_W-1:0]   wrr_credit, wrr_next_credit;

  // Weight 0 behaves as weight 1 so a queue can never be starved by its own setting.
  function automatic logic [WEIGHT_W-1:0] eff_weight(input logic [PRIO_W-1:0] p);
    logic [WEIGHT_W-1:0] w;
    w = wrr_weights[32'(p) * WEIGHT_W +: WEIGHT_W];
    return (w == '0) ? WEIGHT_W'(1) : w;
  endfunction

  always_comb begin
    sp_found   = 1'b0;
    sp_win     = '0;
    srch_found = 1'b0;
    srch_win   = '0;
    idx        = '0;
    // Highest set index wins: later iterations overwrite earlier ones.
    for (int unsigned i = 0; i < NUM_PRIO; i++) begin
      if (prepared[PRIO_W'(i)]) begin
        sp_found = 1'b1;
        sp_win   = PRIO_W'(i);
      end
    end
    // Downward search from ptr-1 with wrap; the last candidate is ptr itself, which
    // matters when it is the only prepared queue but has used up its credit.
    for (int unsigned k = 1; k <= NUM_PRIO; k++) begin
      idx = PRIO_W'((32'(ptr_q) + NUM_PRIO - k) % NUM_PRIO);
      if (prepared[idx] && !srch_found) begin
        srch_found = 1'b1;
        srch_win   = idx;
      end
    end
    stay       = prepared[ptr_q] && (credit_q < eff_weight(ptr_q));
    wrr_win    = stay ? ptr_q : srch_win;
    wrr_credit = stay ? credit_q + WEIGHT_W'(1) : WEIGHT_W'(1);
    // Quantum used up: hand the pointer to the next lower queue and start afresh.
    if (wrr_credit == eff_weight(wrr_win)) begin
      wrr_ptr         = (wrr_win == '0) ? LastPrio : wrr_win - PRIO_W'(1);
      wrr_next_credit = '0;
    end else begin
      wrr_ptr         = wrr_win;
      wrr_next_credit = wrr_credit;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    credit_d     = credit_q;
    grant_d      = grant;
    grant_prio_d = grant_prio;
    addr_req_d   = addr_req;
    sram_en_d    = 1'b0;
    sram_addr_d  = sram_addr;
    rd_sop_d     = 1'b0;
    rd_eop_d     = 1'b0;
    // Read data returns the cycle after each enable; rd_data holds between beats.
    rd_vld_d     = sram_en;
    rd_data_d    = sram_en ? mem_data : rd_data;

    unique case (state_q)
      StIdle: begin
        if (ready && |prepared) state_d = StArb;
      end
      StArb: begin
        if (!sp_found) begin
          // Queues emptied between IDLE and ARB: nothing to send.
          state_d = StIdle;
        end else begin
          state_d    = StSop;
          rd_sop_d   = 1'b1;
          addr_req_d = 1'b1;
          if (sp0_wrr1) begin
            grant_d      = NUM_PRIO'(1) << wrr_win;
            grant_prio_d = wrr_win;
            ptr_d        = wrr_ptr;
            credit_d     = wrr_next_credit;
          end else begin
            grant_d      = NUM_PRIO'(1) << sp_win;
            grant_prio_d = sp_win;
          end
        end
      end
      StSop: state_d = StData;
      StData: begin
        if (addr_vld) begin
          sram_en_d   = 1'b1;
          sram_addr_d = addr_in;
          if (addr_last) begin
            addr_req_d = 1'b0;
            state_d    = StDrain;
          end
        end
      end
      StDrain: state_d = StEop;
      StEop: begin
        state_d      = StIdle;
        rd_eop_d     = 1'b1;
        grant_d      = '0;
        grant_prio_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= LastPrio;
      credit_q   <= '0;
      grant      <= '0;
      grant_prio <= '0;
      addr_req   <= 1'b0;
      sram_en    <= 1'b0;
      sram_addr  <= '0;
      rd_sop     <= 1'b0;
      rd_vld     <= 1'b0;
      rd_eop     <= 1'b0;
      rd_data    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      credit_q   <= credit_d;
      grant      <= grant_d;
      grant_prio <= grant_prio_d;
      addr_req   <= addr_req_d;
      sram_en    <= sram_en_d;
      sram_addr  <= sram_addr_d;
      rd_sop     <= rd_sop_d;
      rd_vld     <= rd_vld_d;
      rd_eop     <= rd_eop_d;
      rd_data    <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_read_sched_arbiter.sv
// Self-checking bench for read_sched_arbiter: directed scenarios followed by random
// back-to-back packets, checked against a queue-level scheduling model.
module tb_read_sched_arbiter;
  localparam int NP = 8, PW = 3, AW = 17, DW = 64, WW = 5;

  logic clk = 1'b0;
  logic rst, sp0_wrr1, ready, addr_vld, addr_last;
  logic [NP-1:0]    prepared;
  logic [NP*WW-1:0] wrr_weights;
  logic [AW-1:0]    addr_in;
  logic [DW-1:0]    mem_data;
  logic [NP-1:0]    grant;
  logic [PW-1:0]    grant_prio;
  logic             addr_req, sram_en, rd_sop, rd_vld, rd_eop;
  logic [AW-1:0]    sram_addr;
  logic [DW-1:0]    rd_data;

  int checks = 0;
  int errors = 0;
  int m_ptr = NP - 1;
  int m_credit = 0;
  logic [DW-1:0] exp_rd_data = '0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_of(input logic [AW-1:0] a);
    return {32'(a) * 32'h9e3779b1, 15'h1234, a};
  endfunction

  // SRAM: returns the word at the address currently presented on the read port.
  assign mem_data = mem_of(sram_addr);

  read_sched_arbiter dut (
    .clk(clk), .rst(rst), .sp0_wrr1(sp0_wrr1), .ready(ready), .prepared(prepared),
    .wrr_weights(wrr_weights), .addr_in(addr_in), .addr_vld(addr_vld),
    .addr_last(addr_last), .mem_data(mem_data), .grant(grant), .grant_prio(grant_prio),
    .addr_req(addr_req), .sram_en(sram_en), .sram_addr(sram_addr), .rd_sop(rd_sop),
    .rd_vld(rd_vld), .rd_eop(rd_eop), .rd_data(rd_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scheduling rules as stated: SP = highest prepared index; WRR = stay on the
  // pointer queue while it has credit left, else the next prepared queue below it.
  function automatic int model_pick(input bit mode, input logic [NP-1:0] prep,
                                    input logic [NP*WW-1:0] w);
    int win, wt;
    if (!mode) begin
      for (int p = NP - 1; p >= 0; p--) if (prep[p]) return p;
      return -1;
    end
    wt = (w[m_ptr*WW +: WW] == 0) ? 1 : int'(w[m_ptr*WW +: WW]);
    if (prep[m_ptr] && m_credit < wt) begin
      win = m_ptr;
    end else begin
      win = -1;
      for (int k = 1; k <= NP; k++) begin
        if (win < 0 && prep[(m_ptr - k + NP) % NP]) win = (m_ptr - k + NP) % NP;
      end
      m_ptr = win;
      m_credit = 0;
    end
    wt = (w[win*WW +: WW] == 0) ? 1 : int'(w[win*WW +: WW]);
    m_credit++;
    if (m_credit == wt) begin
      m_ptr = (win + NP - 1) % NP;
      m_credit = 0;
    end
    return win;
  endfunction

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = NP - 1;
    m_credit = 0;
    exp_rd_data = '0;
  endtask

  task automatic idle_check(input int n);
    ready = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("idle_sop", rd_sop, 0);
      chk("idle_grant", grant, 0);
      chk("idle_addr_req", addr_req, 0);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at the negedge of the cycle
  // in which rd_eop is visible (DUT back in IDLE), or after a reset sequence.
  // gap_mode: 0 = no gaps, 1 = alternate 1,0,1..., 2 = random.
  task automatic run_pkt(input bit mode, input logic [NP-1:0] prep, input logic [NP*WW-1:0] w,
                         input int nbeats, input int gap_mode, input bit drop_mid,
                         input int rst_beat, input int want);
    int g, sent, last_j;
    bit v, ev1, ev2;
    logic [AW-1:0] a;
    logic [NP-1:0] oh;
    bit vh[$];
    logic [AW-1:0] ah[$];
    sp0_wrr1 = mode;
    prepared = prep;
    wrr_weights = w;
    ready = 1'b1;
    // Address strobes outside DATA must be ignored.
    addr_vld = 1'b1;
    addr_last = 1'b1;
    addr_in = AW'($urandom);
    @(negedge clk);  // ARB
    g = model_pick(mode, prep, w);
    oh = '0;
    oh[g] = 1'b1;
    chk("arb_no_sop", rd_sop, 0);
    addr_in = AW'($urandom);
    @(negedge clk);  // SOP
    chk("sop_pulse", rd_sop, 1);
    chk("sop_grant", grant, oh);
    chk("sop_prio", grant_prio, g);
    if (want >= 0) chk("seq_prio", grant_prio, want);
    chk("sop_addr_req", addr_req, 1);
    chk("sop_sram_en", sram_en, 0);
    addr_in = AW'($urandom);
    @(negedge clk);  // first DATA cycle
    sent = 0;
    last_j = -1;
    for (int j = 0; j < 200; j++) begin
      ev1 = (j >= 1) ? vh[j-1] : 1'b0;
      ev2 = (j >= 2) ? vh[j-2] : 1'b0;
      chk($sformatf("sram_en[%0d]", j), sram_en, ev1);
      if (ev1) chk($sformatf("sram_addr[%0d]", j), sram_addr, ah[j-1]);
      chk($sformatf("rd_vld[%0d]", j), rd_vld, ev2);
      if (ev2) exp_rd_data = mem_of(ah[j-2]);
      chk($sformatf("rd_data[%0d]", j), rd_data, exp_rd_data);
      chk($sformatf("rd_eop[%0d]", j), rd_eop, last_j >= 0 && j == last_j + 3);
      chk($sformatf("addr_req[%0d]", j), addr_req, last_j < 0 || j <= last_j);
      chk($sformatf("grant_hold[%0d]", j), grant,
          (last_j >= 0 && j == last_j + 3) ? '0 : oh);
      chk($sformatf("grant_prio_hold[%0d]", j), grant_prio,
          (last_j >= 0 && j == last_j + 3) ? 0 : g);
      chk($sformatf("sop_low[%0d]", j), rd_sop, 0);
      if (last_j >= 0 && j == last_j + 3) return;
      if (rst_beat > 0 && sent == rst_beat) begin
        rst = 1'b1;
        addr_vld = 1'b0;
        @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_prio", grant_prio, 0);
        chk("rst_addr_req", addr_req, 0);
        chk("rst_sram_en", sram_en, 0);
        chk("rst_sram_addr", sram_addr, 0);
        chk("rst_sop", rd_sop, 0);
        chk("rst_vld", rd_vld, 0);
        chk("rst_eop", rd_eop, 0);
        chk("rst_data", rd_data, 0);
        rst = 1'b0;
        ready = 1'b0;
        m_ptr = NP - 1;
        m_credit = 0;
        exp_rd_data = '0;
        repeat (5) begin
          @(negedge clk);
          chk("post_rst_no_eop", rd_eop, 0);
          chk("post_rst_no_vld", rd_vld, 0);
          chk("post_rst_no_sop", rd_sop, 0);
        end
        return;
      end
      if (last_j < 0) begin
        case (gap_mode)
          0: v = 1'b1;
          1: v = (j % 2 == 0);
          default: v = 1'($urandom_range(0, 1));
        endcase
      end else begin
        v = 1'b0;
      end
      a = AW'($urandom);
      if (v) sent++;
      addr_in = a;
      addr_vld = v | (last_j >= 0 && $urandom_range(0, 1) == 1);
      addr_last = v ? (sent == nbeats) : 1'($urandom_range(0, 1));
      if (v && sent == nbeats) last_j = j;
      vh.push_back(v);
      ah.push_back(a);
      if (drop_mid && j == 1) begin
        ready = 1'b0;
        prepared = prep & ~oh;
      end
      @(negedge clk);
    end
    chk("pkt_complete", rd_eop, 1);
  endtask

  initial begin
    logic [NP*WW-1:0] w2, w0;
    logic [NP-1:0] rp;
    int seq_a[6] = '{7, 7, 0, 0, 7, 7};
    int seq_b[4] = '{7, 1, 1, 7};
    rst = 1'b1;
    ready = 1'b0;
    sp0_wrr1 = 1'b0;
    prepared = '0;
    wrr_weights = '0;
    addr_in = '0;
    addr_vld = 1'b0;
    addr_last = 1'b0;
    w2 = {NP{WW'(2)}};
    w0 = w2;
    w0[7*WW +: WW] = '0;
    repeat (2) @(negedge clk);
    chk("reset_grant", grant, 0);
    chk("reset_addr_req", addr_req, 0);
    chk("reset_sram_en", sram_en, 0);
    chk("reset_sop", rd_sop, 0);
    chk("reset_vld", rd_vld, 0);
    chk("reset_eop", rd_eop, 0);
    chk("reset_data", rd_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // Strict priority, 4-address packet
    run_pkt(1'b0, 8'b0010_0100, w2, 4, 0, 1'b0, 0, 5);
    idle_check(2);

    // WRR, all weights 2, back-to-back
    foreach (seq_a[i]) run_pkt(1'b1, 8'b1000_0001, w2, 2, 0, 1'b0, 0, seq_a[i]);
    idle_check(1);

    // Weight 0 acts as 1
    pulse_reset();
    foreach (seq_b[i]) run_pkt(1'b1, 8'b1000_0010, w0, 1, 0, 1'b0, 0, seq_b[i]);
    idle_check(1);

    // Address gaps 1,0,1,0,1
    run_pkt(1'b0, 8'b0000_1000, w2, 3, 1, 1'b0, 0, 3);
    idle_check(3);

    // Reset after beat 2: pointer returns to 7, so 7 (not 0) wins next
    run_pkt(1'b1, 8'b0000_0001, w2, 4, 0, 1'b0, 2, 0);
    run_pkt(1'b1, 8'b1000_0001, w2, 3, 0, 1'b0, 0, 7);
    idle_check(1);

    // ready and the granted prepared bit drop mid-packet
    run_pkt(1'b0, 8'b0001_0000, w2, 4, 2, 1'b1, 0, 4);
    idle_check(4);

    // Random traffic
    for (int n = 0; n < 24; n++) begin
      rp = NP'($urandom);
      if (rp == '0) rp = 8'b0000_0100;
      run_pkt(1'($urandom_range(0, 1)), rp, (NP*WW)'({$urandom, $urandom}),
              $urandom_range(1, 6), 2, 1'b0, 0, -1);
      if ($urandom_range(0, 3) == 0) idle_check($urandom_range(1, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
